// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for modular exponentiation in the
// Montgomery domain, driving one external Montgomery multiplier via start/done.
module mont_exp_ctrl #(
    parameter int WIDTH   = 1024,
    parameter int E_WIDTH = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_inX,
    input  logic [WIDTH-1:0]   i_inR,
    input  logic [E_WIDTH-1:0] i_inE,
    input  logic [WIDTH-1:0]   i_inM,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_done,
    output logic               o_busy,
    output logic               o_montStart,
    output logic [WIDTH-1:0]   o_montA,
    output logic [WIDTH-1:0]   o_montB,
    output logic [WIDTH-1:0]   o_montM,
    input  logic [WIDTH-1:0]   i_montResult,
    input  logic               i_montDone
);

    localparam int               IDX_W    = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(E_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MU_ISSUE,
        MU_WAIT,
        FINISH
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_nextAcc;
    logic [E_WIDTH-1:0] r_e;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_nextIdx;
    logic               w_accept;

    logic [WIDTH-1:0]   r_result;
    logic               r_done;
    logic               r_busy;
    logic               r_montStart;
    logic [WIDTH-1:0]   r_montA;
    logic [WIDTH-1:0]   r_montB;
    logic [WIDTH-1:0]   r_montM;
    logic [WIDTH-1:0]   w_nextResult;
    logic               w_nextDone;
    logic               w_nextBusy;
    logic               w_nextMontStart;
    logic [WIDTH-1:0]   w_nextMontA;
    logic [WIDTH-1:0]   w_nextMontB;

    assign w_accept = (r_state == IDLE) && i_start;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_e         <= '0;
            r_acc       <= '0;
            r_idx       <= LAST_IDX;
            r_result    <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_montStart <= 1'b0;
            r_montA     <= '0;
            r_montB     <= '0;
            r_montM     <= '0;
        end else begin
            r_state     <= w_nextState;
            r_acc       <= w_nextAcc;
            r_idx       <= w_nextIdx;
            r_result    <= w_nextResult;
            r_done      <= w_nextDone;
            r_busy      <= w_nextBusy;
            r_montStart <= w_nextMontStart;
            r_montA     <= w_nextMontA;
            r_montB     <= w_nextMontB;
            if (w_accept) begin
                r_x     <= i_inX;
                r_e     <= i_inE;
                r_montM <= i_inM;
            end
        end
    end

    // Every exponent bit costs one squaring; a set bit adds one multiply by x.
    always_comb begin
        w_nextState = r_state;
        w_nextAcc   = r_acc;
        w_nextIdx   = r_idx;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = SQ_ISSUE;
                    w_nextAcc   = i_inR;
                    w_nextIdx   = LAST_IDX;
                end
            end
            SQ_ISSUE: w_nextState = SQ_WAIT;
            SQ_WAIT: begin
                if (i_montDone) begin
                    w_nextAcc = i_montResult;
                    if (r_e[r_idx]) begin
                        w_nextState = MU_ISSUE;
                    end else if (r_idx == '0) begin
                        w_nextState = FINISH;
                    end else begin
                        w_nextState = SQ_ISSUE;
                        w_nextIdx   = r_idx - IDX_W'(1);
                    end
                end
            end
            MU_ISSUE: w_nextState = MU_WAIT;
            MU_WAIT: begin
                if (i_montDone) begin
                    w_nextAcc = i_montResult;
                    if (r_idx == '0) begin
                        w_nextState = FINISH;
                    end else begin
                        w_nextState = SQ_ISSUE;
                        w_nextIdx   = r_idx - IDX_W'(1);
                    end
                end
            end
            FINISH:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the state they belong to.
    always_comb begin
        w_nextMontStart = (w_nextState == SQ_ISSUE) || (w_nextState == MU_ISSUE);
        w_nextMontA     = r_montA;
        w_nextMontB     = r_montB;
        w_nextDone      = (w_nextState == FINISH);
        w_nextBusy      = (w_nextState != IDLE);
        w_nextResult    = r_result;
        if (w_nextState == SQ_ISSUE) begin
            w_nextMontA = w_nextAcc;
            w_nextMontB = w_nextAcc;
        end else if (w_nextState == MU_ISSUE) begin
            w_nextMontA = w_nextAcc;
            w_nextMontB = r_x;
        end
        if (w_nextState == FINISH) begin
            w_nextResult = w_nextAcc;
        end
    end

    assign o_result    = r_result;
    assign o_done      = r_done;
    assign o_busy      = r_busy;
    assign o_montStart = r_montStart;
    assign o_montA     = r_montA;
    assign o_montB     = r_montB;
    assign o_montM     = r_montM;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl with a behavioural Montgomery core model
// (M=239, R=256) and a plain-arithmetic modular exponentiation reference.
module tb_mont_exp_ctrl;

    localparam int WIDTH   = 8;
    localparam int E_WIDTH = 4;
    localparam int MOD     = 239;
    localparam int R_MOD_M = 17;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               i_start = 1'b0;
    logic [WIDTH-1:0]   i_inX = '0;
    logic [WIDTH-1:0]   i_inR = '0;
    logic [E_WIDTH-1:0] i_inE = '0;
    logic [WIDTH-1:0]   i_inM = '0;
    logic [WIDTH-1:0]   o_result;
    logic               o_done;
    logic               o_busy;
    logic               o_montStart;
    logic [WIDTH-1:0]   o_montA;
    logic [WIDTH-1:0]   o_montB;
    logic [WIDTH-1:0]   o_montM;
    logic [WIDTH-1:0]   i_montResult = '0;
    logic               i_montDone = 1'b0;

    typedef struct {
        int result;
        int pulses;
    } exp_t;

    exp_t sbQ[$];
    int   rInv = 0;
    int   nVectors = 0;
    int   nFail = 0;
    int   doneCount = 0;
    int   runsExpected = 0;
    int   pulseCnt = 0;

    int         coreLat = 5;
    bit         latRandom = 1'b0;
    bit         spurEnable = 1'b0;
    int         coreCnt = 0;
    bit         coreBusy = 1'b0;
    bit         stable = 1'b1;
    logic [7:0] capA = '0;
    logic [7:0] capB = '0;
    logic [7:0] capM = '0;

    always #5 clk = ~clk;

    mont_exp_ctrl #(
        .WIDTH   (WIDTH),
        .E_WIDTH (E_WIDTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_start      (i_start),
        .i_inX        (i_inX),
        .i_inR        (i_inR),
        .i_inE        (i_inE),
        .i_inM        (i_inM),
        .o_result     (o_result),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .o_montStart  (o_montStart),
        .o_montA      (o_montA),
        .o_montB      (o_montB),
        .o_montM      (o_montM),
        .i_montResult (i_montResult),
        .i_montDone   (i_montDone)
    );

    function automatic int montMul(int a, int b);
        return ((a * b) % MOD) * rInv % MOD;
    endfunction

    function automatic int popcount(int v);
        int n;
        n = 0;
        for (int i = 0; i < E_WIDTH; i++) n += (v >> i) & 1;
        return n;
    endfunction

    // Convert out of Montgomery form, exponentiate with plain arithmetic, convert back.
    function automatic int refModExp(int xt, int e);
        int x;
        int p;
        x = (xt * rInv) % MOD;
        p = 1;
        for (int i = 0; i < e; i++) p = (p * x) % MOD;
        return (p * R_MOD_M) % MOD;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int xt, input int e, input int lat, input bit latRand);
        exp_t ex;
        ex.result = refModExp(xt, e);
        ex.pulses = E_WIDTH + popcount(e);
        sbQ.push_back(ex);
        runsExpected++;
        coreLat   = lat;
        latRandom = latRand;
        i_inX     = 8'(xt);
        i_inR     = 8'(R_MOD_M);
        i_inE     = 4'(e);
        i_inM     = 8'(MOD);
        i_start   = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_inX   = 8'($urandom);
        i_inR   = 8'($urandom);
        i_inE   = 4'($urandom);
        i_inM   = 8'($urandom);
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (o_done === 1'b1) seen = 1'b1;
        end
        if (seen) begin
            @(negedge clk);
        end else begin
            nVectors++;
            nFail++;
            $display("[TB] FAIL %s: no done within 3000 cycles", name);
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            runsExpected -= sbQ.size();
            sbQ.delete();
            @(negedge clk);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and counts core requests per run.
    always @(negedge clk) begin
        if (resetn && o_done === 1'b1) begin
            doneCount++;
            if (sbQ.size() == 0) begin
                nVectors++;
                nFail++;
                $display("[TB] FAIL unexpectedDone: got done=1, expected done=0 (no run pending)");
            end else begin
                exp_t ex;
                ex = sbQ.pop_front();
                checkOutput("result", 32'(o_result), ex.result);
                checkOutput("montStartPulses", pulseCnt, ex.pulses);
                checkOutput("busyAtDone", 32'(o_busy), 1);
            end
            pulseCnt = 0;
        end else if (o_busy !== 1'b1) begin
            pulseCnt = 0;
        end else if (o_montStart === 1'b1) begin
            pulseCnt++;
        end
    end

    // Core model: fixed or random latency, checks operands hold until its done pulse.
    always @(negedge clk) begin
        i_montDone = 1'b0;
        if (o_busy !== 1'b1) coreBusy = 1'b0;
        if (coreBusy) begin
            if (o_montA !== capA || o_montB !== capB || o_montM !== capM) stable = 1'b0;
            coreCnt--;
            if (coreCnt <= 0) begin
                i_montDone   = 1'b1;
                i_montResult = 8'(montMul(int'(capA), int'(capB)));
                coreBusy     = 1'b0;
                checkOutput("operandsStable", 32'(stable), 1);
            end
        end else if (o_montStart === 1'b1) begin
            capA     = o_montA;
            capB     = o_montB;
            capM     = o_montM;
            stable   = 1'b1;
            coreBusy = 1'b1;
            coreCnt  = latRandom ? int'($urandom_range(1, 20)) : coreLat;
            checkOutput("montM", 32'(o_montM), MOD);
        end else if (spurEnable && (o_done === 1'b1 || o_busy === 1'b0)) begin
            i_montDone   = (o_done === 1'b1) ? 1'b1 : 1'($urandom_range(0, 1));
            i_montResult = 8'($urandom);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        for (int r = 1; r < MOD; r++) if (((256 * r) % MOD) == 1) rInv = r;

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetResult", 32'(o_result), 0);
        checkOutput("resetDone", 32'(o_done), 0);
        checkOutput("resetBusy", 32'(o_busy), 0);
        checkOutput("resetMontStart", 32'(o_montStart), 0);
        checkOutput("resetMontA", 32'(o_montA), 0);
        checkOutput("resetMontB", 32'(o_montB), 0);
        checkOutput("resetMontM", 32'(o_montM), 0);
        resetn = 1'b1;
        @(negedge clk);

        applyStimulus(85, 3, 5, 1'b0);
        waitDone("e3");
        applyStimulus(85, 0, 5, 1'b0);
        waitDone("e0");
        applyStimulus(85, 15, 5, 1'b1);
        waitDone("e15");
        for (int n = 0; n < 12; n++) begin
            applyStimulus(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 15)), 5, 1'b1);
            waitDone("random");
        end

        // Hold start high with changing inputs for the whole run.
        applyStimulus(85, 5, 3, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            if (o_done === 1'b1) begin
                seen    = 1'b1;
                i_start = 1'b0;
            end else begin
                i_start = 1'b1;
                i_inE   = 4'($urandom);
                i_inX   = 8'($urandom);
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        if (!seen) begin
            nVectors++;
            nFail++;
            $display("[TB] FAIL hammer: no done within 3000 cycles");
        end
        checkOutput("idleAfterHammer", 32'(o_busy), 0);
        repeat (3) @(negedge clk);
        applyStimulus(200, 11, 2, 1'b0);
        waitDone("afterHammer");

        // Abort during the first squaring wait.
        applyStimulus(85, 9, 5, 1'b0);
        @(negedge clk);
        checkOutput("inSqWait", {30'd0, o_busy, o_montStart}, 2);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midResetBusy", 32'(o_busy), 0);
        checkOutput("midResetMontStart", 32'(o_montStart), 0);
        checkOutput("midResetResult", 32'(o_result), 0);
        checkOutput("midResetDone", 32'(o_done), 0);
        void'(sbQ.pop_back());
        runsExpected--;
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus(85, 3, 5, 1'b0);
        waitDone("afterMidReset");

        // Spurious core done pulses while idle and in the finishing cycle.
        spurEnable = 1'b1;
        repeat (10) @(negedge clk);
        applyStimulus(85, 3, 2, 1'b0);
        waitDone("spurious");
        repeat (10) @(negedge clk);
        spurEnable = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("resultHeld", 32'(o_result), refModExp(85, 3));
        checkOutput("idleAfterSpur", 32'(o_busy), 0);

        checkOutput("doneCount", doneCount, runsExpected);
        checkOutput("scoreboardEmpty", sbQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
        $finish;
    end

endmodule
